// File: rtl/branch_pc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_ctrl
//  Description : Fetch-PC sequencer and control-transfer controller for a
//                5-stage RV32I pipeline. Owns the fetch PC and the
//                instruction-memory request, resolves EX-stage branches,
//                JAL and JALR, flushes IF/ID and ID/EX for one cycle on a
//                redirect and halts (or realigns) on a misaligned target.
//  Options     : `define BRANCH_PC_CTRL_STATS_EN adds the br_total and
//                br_redirects event counters as extra outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_ctrl #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          HALT_ON_MISALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        ex_valid,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs1,
    input  logic        branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        if_valid,
    output logic        flush,
    output logic        misalign
`ifdef BRANCH_PC_CTRL_STATS_EN
    ,
    output logic [31:0] br_total,
    output logic [31:0] br_redirects
`endif
);

    // ------------------------------------------------------------------------
    // Opcode / funct3 constants
    // ------------------------------------------------------------------------
    localparam logic [6:0] C_OPC_BRANCH = 7'h63;
    localparam logic [6:0] C_OPC_JAL    = 7'h6F;
    localparam logic [6:0] C_OPC_JALR   = 7'h67;
    localparam logic [2:0] C_F3_JALR    = 3'b000;

    // ------------------------------------------------------------------------
    // Sequencer states
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        imem_req_q, imem_req_d;
    logic        if_valid_q, if_valid_d;
    logic        flush_q,    flush_d;
    logic        misalign_q, misalign_d;

    // ------------------------------------------------------------------------
    // EX-stage decode and target arithmetic
    // ------------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_i;
    logic [31:0] target_raw;
    logic [31:0] target_fixed;
    logic        target_misaligned;
    logic        redirect;
    logic        halt_now;
    logic        accept;

    assign opcode    = ex_instr[6:0];
    assign funct3    = ex_instr[14:12];
    assign is_branch = (opcode == C_OPC_BRANCH);
    assign is_jal    = (opcode == C_OPC_JAL);
    assign is_jalr   = (opcode == C_OPC_JALR) && (funct3 == C_F3_JALR);

    assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7],
                    ex_instr[30:25], ex_instr[11:8], 1'b0};
    assign imm_j = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12],
                    ex_instr[20], ex_instr[30:21], 1'b0};
    assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};

    // Select the control-transfer target; JALR clears bit 0 of the sum.
    always_comb begin
        target_raw = ex_pc + imm_b;
        if (is_jalr) begin
            target_raw = (ex_rs1 + imm_i) & ~32'd1;
        end else if (is_jal) begin
            target_raw = ex_pc + imm_j;
        end
    end

    assign target_misaligned = (target_raw[1:0] != 2'b00);
    // Realigned target used when the controller is configured to continue.
    assign target_fixed      = {target_raw[31:2], 2'b00};

    // Redirect request from EX; only honoured while in FETCH.
    assign redirect = ex_valid & ((is_branch & branch) | is_jal | is_jalr);
    assign halt_now = redirect & target_misaligned & (HALT_ON_MISALIGN != 0);

    // A request is consumed when memory is ready and the pipe is not held.
    assign accept   = imem_req_q & imem_ready & ~stall;

    // ------------------------------------------------------------------------
    // Next-state and next-output computation for the sequencer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        imem_req_d = imem_req_q;
        if_valid_d = 1'b0;
        flush_d    = 1'b0;
        misalign_d = misalign_q;

        case (state_q)
            ST_BOOT: begin
                // Single idle cycle after reset, then start fetching.
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end

            ST_FETCH: begin
                if (halt_now) begin
                    // Freeze at the offending instruction and stop fetching.
                    state_d    = ST_HALT;
                    pc_d       = ex_pc;
                    imem_req_d = 1'b0;
                    flush_d    = 1'b1;
                    misalign_d = 1'b1;
                end else if (redirect) begin
                    // Redirect beats both stall and sequential increment and
                    // drops any request that was not yet accepted.
                    state_d    = ST_REDIRECT;
                    pc_d       = target_fixed;
                    imem_req_d = 1'b1;
                    flush_d    = 1'b1;
                    misalign_d = misalign_q | target_misaligned;
                end else begin
                    imem_req_d = 1'b1;
                    if (accept) begin
                        pc_d       = pc_q + 32'd4;
                        if_valid_d = 1'b1;
                    end
                end
            end

            ST_REDIRECT: begin
                // EX still holds the squashed shadow here: ignore it.
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
                if (accept) begin
                    pc_d       = pc_q + 32'd4;
                    if_valid_d = 1'b1;
                end
            end

            ST_HALT: begin
                // Terminal until reset.
                imem_req_d = 1'b0;
            end

            default: begin
                state_d    = ST_BOOT;
                imem_req_d = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            imem_req_q <= 1'b0;
            if_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            imem_req_q <= imem_req_d;
            if_valid_q <= if_valid_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign flush     = flush_q;
    assign misalign  = misalign_q;

`ifdef BRANCH_PC_CTRL_STATS_EN
    // ------------------------------------------------------------------------
    // Event counters (only active in FETCH, so frozen once halted)
    // ------------------------------------------------------------------------
    logic [31:0] br_total_q,     br_total_d;
    logic [31:0] br_redirects_q, br_redirects_d;

    // Count SB-type instructions seen and redirects actually taken.
    always_comb begin
        br_total_d     = br_total_q;
        br_redirects_d = br_redirects_q;
        if (state_q == ST_FETCH) begin
            if (ex_valid && is_branch) begin
                br_total_d = br_total_q + 32'd1;
            end
            if (redirect && !halt_now) begin
                br_redirects_d = br_redirects_q + 32'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q     <= 32'd0;
            br_redirects_q <= 32'd0;
        end else begin
            br_total_q     <= br_total_d;
            br_redirects_q <= br_redirects_d;
        end
    end

    assign br_total     = br_total_q;
    assign br_redirects = br_redirects_q;
`endif

endmodule

`default_nettype wire
